board_loader: RTL
=================

# board_loader

Run-length decoder that loads an initial Game of Life board into the double buffer's logic-side write port. It sits between a byte source (UART receiver or pattern ROM streamer) and `double_buffer`, and is the writer counterpart of the renderer's read path. It drives the same `addr_w`/`data_w`/`wr_en` signals that `life_logic` drives. A top-level mux selects between the two while `busy_out` is high. The block follows the same start/done handshake that `synchronizer` uses with `life_logic`.

## Interface

**Parameters**
- `WORD_BITS`, default 16: cells per buffer word (width of `data_t`).
- `BOARD_W_WORDS`, default 32: words per board row (512-cell-wide board).
- `BOARD_H`, default 512: board rows.
- `ADDR_BITS`, default 14: buffer address width. Must hold BOARD_W_WORDS*BOARD_H words.

**Ports**
- `clk_in`, input, 1: single clock (100 MHz domain).
- `rst_in`, input, 1: reset, asynchronous and active-low.
- `start_in`, input, 1: one-cycle pulse that begins a load.
- `byte_in`, input, 8: encoded run byte. bit7 = cell value; bits6:0 = run length − 1.
- `byte_valid_in`, input, 1: `byte_in` is valid.
- `byte_ready_out`, output, 1: loader accepts a byte this cycle.
- `addr_w_out`, output, ADDR_BITS: write word address.
- `data_w_out`, output, WORD_BITS: packed cell word.
- `wr_en_out`, output, 1: write strobe, one cycle per word.
- `busy_out`, output, 1: load in progress.
- `done_out`, output, 1: one-cycle pulse when the load completes.

## Operation

- **States:** IDLE, LOAD, FLUSH, DONE.
- **IDLE:**
  - `start_in` → LOAD.
  - Cell counter, word address and shift register are cleared.
- **LOAD:**
  - `byte_ready_out = (run_cnt == 0)`.
  - A byte is accepted on `byte_valid_in && byte_ready_out`. This loads `run_cnt = bits6:0 + 1` (range 1..128) and latches `run_val = bit7`.
  - Each following cycle with `run_cnt != 0` emits one cell and decrements `run_cnt`.
  - The accept cycle emits no cell, so a run of length L costs L+1 cycles.
- **Cell ordering and packing:**
  - Cells fill the board row-major, starting at word 0.
  - Cells are packed LSB-first: column c goes to bit (c mod WORD_BITS).
  - Runs continue across word and row boundaries.
- **Word writes:**
  - When a word's WORD_BITS-th cell is emitted, the completed word is presented on the next cycle with `wr_en_out = 1`.
  - `addr_w_out` then increments.
  - Cell emission never stalls for writes.
- **Last cell:** when the final cell (BOARD_W_WORDS*WORD_BITS*BOARD_H) is emitted → FLUSH.
  - Any remaining `run_cnt` is discarded (truncation).
  - `byte_ready_out` drops.
- **FLUSH:** issues the last word's write → DONE.
- **DONE:**
  - `done_out = 1` for one cycle → IDLE.
- **Busy and start:**
  - `busy_out = 1` in LOAD, FLUSH and DONE.
  - `start_in` is ignored whenever the state is not IDLE.
- **Address wrap:** the address counter never wraps during a load. It stops at the last word and returns to 0 in IDLE.

## Timing

- **Reset values:** every output is 0 (`byte_ready_out`, `addr_w_out`, `data_w_out`, `wr_en_out`, `busy_out`, `done_out`). State is IDLE.
- **Start:** with `start_in` at cycle 0, `busy_out` and `byte_ready_out` are 1 from cycle 1.
- **Write latency:** the write strobe comes one cycle after the word's last cell is emitted.
- **Done latency:** `done_out` comes one cycle after the final write.
- **Throughput:** one cell per cycle while runs are pending.
- **Source stalls:** a low `byte_valid_in` only inserts idle cycles. Output words and addresses are unaffected.
- **Reset mid-load:** asserting `rst_in` aborts immediately.
  - All outputs go to 0 and no partial word is written.
  - The next `start_in` restarts at address 0.
- **Simultaneous events:** a `start_in` coinciding with `done_out` is ignored.

## Test plan

Benches use WORD_BITS=4, BOARD_W_WORDS=2, BOARD_H=2, ADDR_BITS=2: 16 cells, 4 words.

1. **Single long run:** start at cycle 0, then byte 0x8F (alive, 16 cells) accepted at cycle 1.
   - Writes 0xF to addr 0,1,2,3 at cycles 6, 10, 14, 18.
   - `done_out` at cycle 19; `busy_out` low at cycle 20.
2. **Alternating cells:** byte pairs 0x80, 0x00 repeated 8 times.
   - Four writes of 0x5, to addr 0..3, then one `done_out` pulse.
3. **Overflow truncation:** single byte 0x9F (alive, 32 cells).
   - Exactly 4 writes of 0xF, one `done_out` pulse.
   - `byte_ready_out` stays 0 afterward; a further valid byte is never accepted.
4. **Throttled source:** scenario 2 with `byte_valid_in` randomly low 50% of cycles.
   - Identical write data and address sequence.
5. **Reset mid-load:** scenario 1 with `rst_in` pulled low after the second write.
   - All outputs read 0 during reset.
   - After release, a new start plus 0x0F writes 0x0 to addr 0..3.
6. **Start while busy:** `start_in` pulses at cycles 3 and 19 of scenario 1.
   - No change to the write sequence, exactly one `done_out` pulse, returns to IDLE.

Source files
------------

// File: rtl/board_loader.sv
// rtl/board_loader.sv - run-length decoder that writes an initial Life board into the double buffer
module board_loader #(
   parameter int WORD_BITS     = 16,
   parameter int BOARD_W_WORDS = 32,
   parameter int BOARD_H       = 512,
   parameter int ADDR_BITS     = 14
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 start_in,
   input  logic [7:0]           byte_in,
   input  logic                 byte_valid_in,
   output logic                 byte_ready_out,
   output logic [ADDR_BITS-1:0] addr_w_out,
   output logic [WORD_BITS-1:0] data_w_out,
   output logic                 wr_en_out,
   output logic                 busy_out,
   output logic                 done_out
);

   localparam int TOTAL_CELLS = BOARD_W_WORDS * WORD_BITS * BOARD_H;
   localparam int CELL_BITS   = (TOTAL_CELLS > 1) ? $clog2(TOTAL_CELLS) : 1;
   localparam int BIT_BITS    = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
   localparam logic [CELL_BITS-1:0] LAST_CELL = CELL_BITS'(TOTAL_CELLS - 1);
   localparam logic [BIT_BITS-1:0]  LAST_BIT  = BIT_BITS'(WORD_BITS - 1);
   localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(BOARD_W_WORDS * BOARD_H - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

   state_t                 state, state_nxt;
   logic [7:0]             run_cnt;
   logic                   run_val;
   logic [CELL_BITS-1:0]   cell_cnt;
   logic [BIT_BITS-1:0]    bit_idx;
   logic [WORD_BITS-1:0]   shift_reg;
   logic [WORD_BITS-1:0]   word_nxt;
   logic [ADDR_BITS-1:0]   word_addr;
   logic [WORD_BITS-1:0]   data_q;
   logic                   wr_q;
   logic                   accept;
   logic                   emit;
   logic                   last_cell;
   logic                   word_full;

   always_comb begin
      accept    = (state == S_LOAD) && (run_cnt == 8'd0) && byte_valid_in;
      emit      = (state == S_LOAD) && (run_cnt != 8'd0);
      last_cell = emit && (cell_cnt == LAST_CELL);
      word_full = emit && (bit_idx == LAST_BIT);
      word_nxt  = shift_reg;
      word_nxt[bit_idx] = run_val;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start_in) state_nxt = S_LOAD;
         S_LOAD:  if (last_cell) state_nxt = S_FLUSH;
         S_FLUSH: state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         run_cnt   <= '0;
         run_val   <= 1'b0;
         cell_cnt  <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         word_addr <= '0;
         data_q    <= '0;
         wr_q      <= 1'b0;
      end else begin
         wr_q <= 1'b0;
         // Address advances after each write but parks on the last word.
         if (wr_q && (word_addr != LAST_ADDR))
            word_addr <= word_addr + ADDR_BITS'(1);
         case (state)
            S_LOAD: begin
               if (accept) begin
                  run_cnt <= {1'b0, byte_in[6:0]} + 8'd1;
                  run_val <= byte_in[7];
               end else if (emit) begin
                  run_cnt  <= last_cell ? 8'd0 : run_cnt - 8'd1;
                  cell_cnt <= cell_cnt + CELL_BITS'(1);
                  if (word_full) begin
                     data_q    <= word_nxt;
                     wr_q      <= 1'b1;
                     shift_reg <= '0;
                     bit_idx   <= '0;
                  end else begin
                     shift_reg <= word_nxt;
                     bit_idx   <= bit_idx + BIT_BITS'(1);
                  end
               end
            end
            S_FLUSH: run_cnt <= '0;
            default: begin
               run_cnt   <= '0;
               run_val   <= 1'b0;
               cell_cnt  <= '0;
               bit_idx   <= '0;
               shift_reg <= '0;
               word_addr <= '0;
               data_q    <= '0;
            end
         endcase
      end
   end

   assign byte_ready_out = (state == S_LOAD) && (run_cnt == 8'd0);
   assign addr_w_out     = word_addr;
   assign data_w_out     = data_q;
   assign wr_en_out      = wr_q;
   assign busy_out       = (state != S_IDLE);
   assign done_out       = (state == S_DONE);

endmodule
